// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-RAM loader and its target RAM:
// geometry defaults, frame layout constants and the loader state encoding.
package imem_loader_pkg;

   localparam int IMEM_DEPTH = 64;
   localparam int IMEM_AW    = $clog2(IMEM_DEPTH);

   // Frame layout: two little-endian count bytes, 4*N payload bytes, one XOR checksum byte.
   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_PAY,
      S_WR,
      S_CSUM,
      S_DONE
   } state_t;

   function automatic logic accepts_byte(state_t s);
      return (s == S_HDR0) || (s == S_HDR1) || (s == S_PAY) || (s == S_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the loader (UART/JTAG bridge side).
interface imem_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_ram.sv
// Writable instruction RAM: synchronous word write port, asynchronous
// ROM-compatible read port (byte address, addr[AW+1:2] selects the word).
module imem_ram
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW    = IMEM_AW
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic [9:0]    addr,
   output logic [63:0]   data
);

   logic [31:0] mem [DEPTH];
   logic        unused_addr_bits;

   // NOTE: storage is deliberately not reset; contents are defined only by loads.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign data             = {32'h0, mem[addr[AW+1:2]]};
   assign unused_addr_bits = ^{addr[9:AW+2], addr[1:0]};

endmodule

// File: rtl/imem_loader.sv
// Packs a framed little-endian byte stream into 32-bit words, writes them to the
// instruction RAM from word 0 upward and holds the core until the load finishes.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW    = IMEM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic          cpu_hold,
   output logic          done,
   output logic          err,
   output logic [AW:0]   words_loaded,
   input  logic [9:0]    rd_addr,
   output logic [63:0]   rd_data
);

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [31:0] pack;
   logic [7:0]  csum;
   logic [15:0] count;
   logic [15:0] n_hdr;
   logic        take;
   logic        last_word;

   // NOTE: in_ready is a pure decode of the state register, so it changes only on clock edges.
   assign bus.in_ready = accepts_byte(state);
   assign take         = bus.in_valid & bus.in_ready;
   assign n_hdr        = {bus.in_data, count[7:0]};
   assign last_word    = (16'(words_loaded) == count - 16'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         byte_cnt     <= '0;
         pack         <= '0;
         csum         <= '0;
         count        <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         cpu_hold     <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state        <= S_HDR0;
                  cpu_hold     <= 1'b1;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  words_loaded <= '0;
                  byte_cnt     <= '0;
                  csum         <= '0;
                  count        <= '0;
               end
            end
            S_HDR0: begin
               if (take) begin
                  count[7:0] <= bus.in_data;
                  state      <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (take) begin
                  count[15:8] <= bus.in_data;
                  if (n_hdr == '0 || n_hdr > 16'(DEPTH)) begin
                     state    <= S_DONE;
                     err      <= 1'b1;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= S_PAY;
                  end
               end
            end
            S_PAY: begin
               if (take) begin
                  pack[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
                  csum     <= csum ^ bus.in_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  // The last byte bypasses the pack register so the write issues next cycle.
                  if (byte_cnt == 2'(WORD_BYTES - 1)) begin
                     state   <= S_WR;
                     wr_en   <= 1'b1;
                     wr_addr <= words_loaded[AW-1:0];
                     wr_data <= {bus.in_data, pack[23:0]};
                  end
               end
            end
            S_WR: begin
               words_loaded <= words_loaded + 1'b1;
               state        <= last_word ? S_CSUM : S_PAY;
            end
            S_CSUM: begin
               if (take) begin
                  err      <= (csum != bus.in_data);
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  state    <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .addr    (rd_addr),
      .data    (rd_data)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, bad headers, full image with
// stream gaps, reset mid-load and a stray start mid-payload.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               wr_en;
   logic [IMEM_AW-1:0] wr_addr;
   logic [31:0]        wr_data;
   logic               cpu_hold;
   logic               done;
   logic               err;
   logic [IMEM_AW:0]   words_loaded;
   logic [9:0]         rd_addr;
   logic [63:0]        rd_data;

   imem_loader_if bus ();

   imem_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus.slave),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data)
   );

   always #5 clk = ~clk;

   int                 n_checks   = 0;
   int                 n_pass     = 0;
   int                 wr_count   = 0;
   int                 ready_viol = 0;
   int                 hold_viol  = 0;
   logic               loading    = 1'b0;
   logic [IMEM_AW-1:0] wq_addr [$];
   logic [31:0]        wq_data [$];
   logic [31:0]        img [IMEM_DEPTH];

   // Write-port monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wq_addr.push_back(wr_addr);
         wq_data.push_back(wr_data);
         wr_count++;
         if (bus.in_ready !== 1'b0) ready_viol++;
         if (cpu_hold !== 1'b1) hold_viol++;
      end
      if (loading && done !== 1'b1 && cpu_hold !== 1'b1) hold_viol++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && t < 64) begin
         @(negedge clk);
         t++;
      end
      if (t >= 64) check("in_ready_timeout", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Sends header, img[0..n-1] and a checksum (true XOR unless force_cs is set).
   task automatic send_frame(input int n, input bit force_cs, input logic [7:0] cs_val,
                             input int maxgap, input int mid_start);
      logic [7:0] cs = 8'h00;
      logic [7:0] b;
      send_byte(n[7:0], 0);
      send_byte(n[15:8], 0);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            b  = img[i][8*k +: 8];
            cs = cs ^ b;
            if (i * 4 + k == mid_start) pulse_start();
            send_byte(b, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
         end
      end
      send_byte(force_cs ? cs_val : cs, 0);
   endtask

   task automatic wait_done();
      int t = 0;
      while (done !== 1'b1 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check("done_timeout", 64'(done), 64'(1));
   endtask

   task automatic check_writes(input string tag, input int base, input int n);
      check({tag, "_wr_count"}, 64'(wr_count - base), 64'(n));
      for (int i = 0; i < n && base + i < wq_addr.size(); i++) begin
         check({tag, "_wr_addr"}, 64'(wq_addr[base + i]), 64'(i));
         check({tag, "_wr_data"}, 64'(wq_data[base + i]), 64'(img[i]));
      end
   endtask

   task automatic check_status(input string tag, input logic e_err, input int e_words);
      check({tag, "_done"}, 64'(done), 64'(1));
      check({tag, "_err"}, 64'(err), 64'(e_err));
      check({tag, "_words"}, 64'(words_loaded), 64'(e_words));
      check({tag, "_hold"}, 64'(cpu_hold), 64'(0));
      check({tag, "_ready"}, 64'(bus.in_ready), 64'(0));
   endtask

   initial begin
      int base;
      rst          = 1'b1;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      rd_addr      = 10'h000;
      repeat (3) @(negedge clk);

      check("rst_ready", 64'(bus.in_ready), 64'(0));
      check("rst_wr_en", 64'(wr_en), 64'(0));
      check("rst_wr_addr", 64'(wr_addr), 64'(0));
      check("rst_wr_data", 64'(wr_data), 64'(0));
      check("rst_hold", 64'(cpu_hold), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_words", 64'(words_loaded), 64'(0));
      rst = 1'b0;

      // Two-word frame with correct checksum (B7^02^93^82^A2 = 0x06).
      img[0] = 32'h000002B7;
      img[1] = 32'h00A28293;
      base = wr_count;
      pulse_start();
      check("t1_hold_after_start", 64'(cpu_hold), 64'(1));
      check("t1_ready_hdr0", 64'(bus.in_ready), 64'(1));
      send_frame(2, 1'b1, 8'h06, 0, -1);
      check_status("t1", 1'b0, 2);
      check_writes("t1", base, 2);
      @(negedge clk);
      rd_addr = 10'h004;
      #1;
      check("t1_rd_word1", rd_data, {32'h0, 32'h00A28293});

      // Same frame, checksum 0x00.
      base = wr_count;
      pulse_start();
      check("t2_done_cleared", 64'(done), 64'(0));
      check("t2_words_cleared", 64'(words_loaded), 64'(0));
      send_frame(2, 1'b1, 8'h00, 0, -1);
      check_status("t2", 1'b1, 2);
      check_writes("t2", base, 2);

      // Bad headers: N=0 and N=65.
      base = wr_count;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check_status("t3_n0", 1'b1, 0);
      pulse_start();
      check("t3_err_cleared", 64'(err), 64'(0));
      send_byte(8'h41, 0);
      send_byte(8'h00, 0);
      check_status("t3_n65", 1'b1, 0);
      repeat (3) @(negedge clk);
      check("t3_no_writes", 64'(wr_count - base), 64'(0));

      // Full 64-word image with random stream gaps.
      for (int i = 0; i < IMEM_DEPTH; i++) img[i] = $urandom;
      base = wr_count;
      ready_viol = 0;
      hold_viol  = 0;
      pulse_start();
      loading = 1'b1;
      send_frame(IMEM_DEPTH, 1'b0, 8'h00, 3, -1);
      wait_done();
      loading = 1'b0;
      check_status("t4", 1'b0, IMEM_DEPTH);
      check_writes("t4", base, IMEM_DEPTH);
      check("t4_ready_during_wr", 64'(ready_viol), 64'(0));
      check("t4_hold_during_load", 64'(hold_viol), 64'(0));
      @(negedge clk);
      rd_addr = 10'h0FC;
      #1;
      check("t4_rd_word63", rd_data, {32'h0, img[63]});

      // Reset after five payload bytes of a 4-word frame.
      base = wr_count;
      pulse_start();
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      for (int j = 0; j < 5; j++) send_byte(img[j / 4][8 * (j % 4) +: 8], 0);
      check("t5_one_write_before_rst", 64'(wr_count - base), 64'(1));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_rst_ready", 64'(bus.in_ready), 64'(0));
      check("t5_rst_wr_en", 64'(wr_en), 64'(0));
      check("t5_rst_wr_addr", 64'(wr_addr), 64'(0));
      check("t5_rst_wr_data", 64'(wr_data), 64'(0));
      check("t5_rst_hold", 64'(cpu_hold), 64'(0));
      check("t5_rst_done", 64'(done), 64'(0));
      check("t5_rst_err", 64'(err), 64'(0));
      check("t5_rst_words", 64'(words_loaded), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_no_write_after_rst", 64'(wr_count - base), 64'(1));
      base = wr_count;
      pulse_start();
      send_frame(4, 1'b0, 8'h00, 0, -1);
      check_status("t5_reload", 1'b0, 4);
      check_writes("t5_reload", base, 4);

      // Stray start in the middle of the payload.
      base = wr_count;
      pulse_start();
      send_frame(3, 1'b0, 8'h00, 1, 6);
      check_status("t6", 1'b0, 3);
      check_writes("t6", base, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
